bb_and_sequencer: RTL and testbench



---
 rtl/bb_and_sequencer_pkg.sv | 21 ++
 rtl/bb_and_sequencer_if.sv | 9 +
 rtl/bb_and_sequencer_lfsr8.sv | 36 +++
 rtl/bb_and_sequencer.sv | 152 +++++++++++++++
 tb/tb_bb_and_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bb_and_sequencer_pkg.sv
// Shared types and constants for the black-box AND operand sequencer.
package bb_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Taps at bits 7,5,4,3 for x^8+x^6+x^5+x^4+1 in a left-shifting register.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Bits needed to hold any count 0..n inclusive; never below 1.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bb_and_sequencer_if.sv
// Boundary between the sequencer and the black-box AND wrapper.
interface bb_and_sequencer_if;
  logic a;
  logic b;
  logic result;

  modport seq  (output a, output b, input result);
  modport wrap (input a, input b, output result);
endinterface

// File: rtl/bb_and_sequencer_lfsr8.sv
// 8-bit Fibonacci LFSR; load has priority over step.
module bb_lfsr8
  import bb_seq_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] seed_i,
  input  logic       step_i,
  output logic [7:0] state_o
);

  logic [7:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = {state_q[6:0], ^(state_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/bb_and_sequencer.sv
// BIST sequencer: drives operand pairs into the black-box AND and scores its result.
module bb_and_sequencer
  import bb_seq_pkg::*;
#(
  parameter int         NUM_VECTORS   = 16,
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [7:0] LFSR_SEED     = 8'hA5,
  parameter int         COUNT_W       = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_start,
  output logic               io_busy,
  output logic               io_done,
  output logic               io_a,
  output logic               io_b,
  input  logic               io_result,
  output logic [COUNT_W-1:0] io_passCount,
  output logic [COUNT_W-1:0] io_failCount,
  output logic               io_firstFailValid,
  output logic [7:0]         io_firstFailIdx,
  output state_t             dbg_state_o
);

  localparam int IDX_W = idx_width(NUM_VECTORS);
  localparam int SET_W = idx_width(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VECTORS - 1);
  localparam logic [SET_W-1:0] SETTLE_RLD = SET_W'(SETTLE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               a_q, a_d, b_q, b_d;
  logic [COUNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic               ffv_q, ffv_d;
  logic [7:0]         ffidx_q, ffidx_d;

  logic       lfsr_load, lfsr_step;
  logic [7:0] lfsr_state;
  logic [1:0] next_idx_lo;
  logic       next_is_lfsr;
  logic       unused_lfsr_hi;

  bb_lfsr8 #(.RESET_VAL(LFSR_SEED)) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .load_i  (lfsr_load),
    .seed_i  (LFSR_SEED),
    .step_i  (lfsr_step),
    .state_o (lfsr_state)
  );

  assign unused_lfsr_hi = ^lfsr_state[7:2];
  assign next_idx_lo    = 2'(32'(idx_q) + 32'd1);
  assign next_is_lfsr   = (32'(idx_q) >= 32'd3);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    a_d       = a_q;
    b_d       = b_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ffv_d     = ffv_q;
    ffidx_d   = ffidx_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (io_start) begin
          pass_d    = '0;
          fail_d    = '0;
          ffv_d     = 1'b0;
          ffidx_d   = '0;
          lfsr_load = 1'b1;
          idx_d     = '0;
          a_d       = 1'b0;
          b_d       = 1'b0;
          settle_d  = SETTLE_RLD;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_SAMPLE;
          // Advance the LFSR one edge early so the next LFSR-sourced vector is ready on SAMPLE exit.
          lfsr_step = next_is_lfsr && (idx_q != LAST_IDX);
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (io_result == (a_q & b_q)) begin
          pass_d = (&pass_q) ? pass_q : pass_q + COUNT_W'(1);
        end else begin
          fail_d = (&fail_q) ? fail_q : fail_q + COUNT_W'(1);
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffidx_d = 8'(idx_q);
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d    = idx_q + IDX_W'(1);
          a_d      = next_is_lfsr ? lfsr_state[1] : next_idx_lo[1];
          b_d      = next_is_lfsr ? lfsr_state[0] : next_idx_lo[0];
          settle_d = SETTLE_RLD;
          state_d  = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      pass_q   <= '0;
      fail_q   <= '0;
      ffv_q    <= 1'b0;
      ffidx_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ffv_q    <= ffv_d;
      ffidx_q  <= ffidx_d;
    end
  end

  assign io_busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign io_done           = (state_q == ST_DONE);
  assign io_a              = a_q;
  assign io_b              = b_q;
  assign io_passCount      = pass_q;
  assign io_failCount      = fail_q;
  assign io_firstFailValid = ffv_q;
  assign io_firstFailIdx   = ffidx_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_bb_and_sequencer.sv
// Bench for bb_and_sequencer: two instances (4-vector run, and 8-vector run with 2-bit counters).
module tb_bb_and_sequencer;
  import bb_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  int   cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  bb_and_sequencer_if bus_a ();
  bb_and_sequencer_if bus_s ();

  logic [1:0] mode_a;  // 0: correct AND, 1: stuck-at-0, 2: stuck-at-1
  assign bus_a.result = (mode_a == 2'd1) ? 1'b0 : (mode_a == 2'd2) ? 1'b1 : (bus_a.a & bus_a.b);
  assign bus_s.result = bus_s.a & bus_s.b;

  logic        start_a, start_s;
  logic        busy_a, done_a, ffv_a, busy_s, done_s, ffv_s;
  logic [15:0] pass_a, fail_a;
  logic [1:0]  pass_s, fail_s;
  logic [7:0]  ffidx_a, ffidx_s;
  state_t      st_a, st_s;

  bb_and_sequencer #(.NUM_VECTORS(4), .SETTLE_CYCLES(1), .LFSR_SEED(8'hA5), .COUNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .io_start(start_a), .io_busy(busy_a), .io_done(done_a),
    .io_a(bus_a.a), .io_b(bus_a.b), .io_result(bus_a.result),
    .io_passCount(pass_a), .io_failCount(fail_a), .io_firstFailValid(ffv_a),
    .io_firstFailIdx(ffidx_a), .dbg_state_o(st_a)
  );

  bb_and_sequencer #(.NUM_VECTORS(8), .SETTLE_CYCLES(1), .LFSR_SEED(8'hA5), .COUNT_W(2)) dut_s (
    .clock(clock), .reset(reset), .io_start(start_s), .io_busy(busy_s), .io_done(done_s),
    .io_a(bus_s.a), .io_b(bus_s.b), .io_result(bus_s.result),
    .io_passCount(pass_s), .io_failCount(fail_s), .io_firstFailValid(ffv_s),
    .io_firstFailIdx(ffidx_s), .dbg_state_o(st_s)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] pass;
    logic [15:0] fail;
    logic        ffv;
    logic [7:0]  idx;
    int          lat;
  } res_t;

  logic [1:0] exp_ab_a[$];
  logic [1:0] exp_ab_s[$];
  res_t       exp_res_a[$];
  res_t       exp_res_s[$];
  int         start_cyc_a, start_cyc_s;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_missing(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got output with nothing expected (cycle %0d)", name, cyc);
  endtask

  task automatic check_res(input string tag, input res_t e, input logic [15:0] p, input logic [15:0] f,
                           input logic v, input logic [7:0] i, input int lat);
    check({tag, "_pass"}, 32'(p), 32'(e.pass));
    check({tag, "_fail"}, 32'(f), 32'(e.fail));
    check({tag, "_ffv"}, 32'(v), 32'(e.ffv));
    check({tag, "_ffidx"}, 32'(i), 32'(e.idx));
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
  endtask

  // ---------------- monitors ----------------
  logic done_a_prev = 1'b0;
  logic done_s_prev = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      if (st_a == ST_SAMPLE) begin
        if (exp_ab_a.size() == 0) report_missing("ab_a");
        else check("ab_a", 32'({bus_a.a, bus_a.b}), 32'(exp_ab_a.pop_front()));
      end
      if (done_a && !done_a_prev) begin
        if (exp_res_a.size() == 0) report_missing("res_a");
        else check_res("res_a", exp_res_a.pop_front(), pass_a, fail_a, ffv_a, ffidx_a,
                       cyc - start_cyc_a + 1);
      end
      check("busy_done_a", 32'(busy_a & done_a), 32'd0);
    end
    done_a_prev = done_a;
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (st_s == ST_SAMPLE) begin
        if (exp_ab_s.size() == 0) report_missing("ab_s");
        else check("ab_s", 32'({bus_s.a, bus_s.b}), 32'(exp_ab_s.pop_front()));
      end
      if (done_s && !done_s_prev) begin
        if (exp_res_s.size() == 0) report_missing("res_s");
        else check_res("res_s", exp_res_s.pop_front(), 16'(pass_s), 16'(fail_s), ffv_s, ffidx_s,
                       cyc - start_cyc_s + 1);
      end
      check("busy_done_s", 32'(busy_s & done_s), 32'd0);
    end
    done_s_prev = done_s;
  end

  // ---------------- driver tasks ----------------
  task automatic push_exhaustive_a();
    exp_ab_a.push_back(2'b00);
    exp_ab_a.push_back(2'b01);
    exp_ab_a.push_back(2'b10);
    exp_ab_a.push_back(2'b11);
  endtask

  task automatic push_res_a(input logic [15:0] p, input logic [15:0] f, input logic v,
                            input logic [7:0] i);
    res_t r;
    r.pass = p; r.fail = f; r.ffv = v; r.idx = i; r.lat = 9;
    exp_res_a.push_back(r);
  endtask

  task automatic start_pulse_a();
    @(negedge clock);
    start_a     = 1'b1;
    start_cyc_a = cyc + 1;
    @(negedge clock);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_a_timeout: got no done within %0d cycles, required done", budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_done"}, 32'(done_a), 32'd0);
    check({tag, "_ab"}, 32'({bus_a.a, bus_a.b}), 32'd0);
    check({tag, "_pass"}, 32'(pass_a), 32'd0);
    check({tag, "_fail"}, 32'(fail_a), 32'd0);
    check({tag, "_ffv"}, 32'(ffv_a), 32'd0);
    check({tag, "_ffidx"}, 32'(ffidx_a), 32'd0);
    check({tag, "_state"}, 32'(st_a), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    res_t rs;
    reset   = 1'b1;
    start_a = 1'b0;
    start_s = 1'b0;
    mode_a  = 2'd0;
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    check("rst_pass_s", 32'(pass_s), 32'd0);
    check("rst_done_s", 32'(done_s), 32'd0);
    reset = 1'b0;

    // Correct AND model.
    mode_a = 2'd0;
    push_exhaustive_a();
    push_res_a(16'd4, 16'd0, 1'b0, 8'd0);
    start_pulse_a();
    wait_done_a(20);

    // Stuck-at-0: only the 11 vector (index 3) mismatches.
    mode_a = 2'd1;
    push_exhaustive_a();
    push_res_a(16'd3, 16'd1, 1'b1, 8'd3);
    start_pulse_a();
    wait_done_a(20);

    // Stuck-at-1: indices 0,1,2 mismatch, first is 0.
    mode_a = 2'd2;
    push_exhaustive_a();
    push_res_a(16'd1, 16'd3, 1'b1, 8'd0);
    start_pulse_a();
    wait_done_a(20);

    // Start while busy is ignored; restart from DONE replays the run.
    mode_a = 2'd0;
    push_exhaustive_a();
    push_res_a(16'd4, 16'd0, 1'b0, 8'd0);
    start_pulse_a();
    @(negedge clock);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    wait_done_a(20);
    push_exhaustive_a();
    push_res_a(16'd4, 16'd0, 1'b0, 8'd0);
    start_pulse_a();
    wait_done_a(20);

    // Reset mid-run: only vectors 0 and 1 reach SAMPLE before reset lands.
    exp_ab_a.push_back(2'b00);
    exp_ab_a.push_back(2'b01);
    start_pulse_a();
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("midrst");
    reset = 1'b0;
    push_exhaustive_a();
    push_res_a(16'd4, 16'd0, 1'b0, 8'd0);
    start_pulse_a();
    wait_done_a(20);

    // Saturation with 2-bit counters; vectors 4..7 from LFSR states 4A,95,2A,54.
    exp_ab_s.push_back(2'b00);
    exp_ab_s.push_back(2'b01);
    exp_ab_s.push_back(2'b10);
    exp_ab_s.push_back(2'b11);
    exp_ab_s.push_back(2'b10);
    exp_ab_s.push_back(2'b01);
    exp_ab_s.push_back(2'b10);
    exp_ab_s.push_back(2'b00);
    rs.pass = 16'd3; rs.fail = 16'd0; rs.ffv = 1'b0; rs.idx = 8'd0; rs.lat = 17;
    exp_res_s.push_back(rs);
    @(negedge clock);
    start_s     = 1'b1;
    start_cyc_s = cyc + 1;
    @(negedge clock);
    start_s = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clock);
        if (done_s) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_s_timeout: got no done within 40 cycles, required done");
      end
    end

    repeat (3) @(negedge clock);
    check("queue_ab_a_left", 32'(exp_ab_a.size()), 32'd0);
    check("queue_res_a_left", 32'(exp_res_a.size()), 32'd0);
    check("queue_ab_s_left", 32'(exp_ab_s.size()), 32'd0);
    check("queue_res_s_left", 32'(exp_res_s.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
